// File: rtl/alu_pkg.sv
// Shared encodings for the Lab 3 ALU: controller FSM states and ALU op codes.
// Imported by the controller, the ALU datapath and the display decoder.
package alu_pkg;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_ADD = 3'd2,
    S_SUB = 3'd3,
    S_MOD = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;

  // Operand-capture states report ADD so the ALU never sees the unused code 11.
  function automatic logic [1:0] op_of_state(input state_t s);
    case (s)
      S_SUB:   op_of_state = OP_SUB;
      S_MOD:   op_of_state = OP_MOD;
      default: op_of_state = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_edge_detect.sv
// Rising-edge press detector on a debounced level: one-cycle press per rise.
// Press is combinational off the level; history register clears on reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (rst) r_level_q <= 1'b0;
    else     r_level_q <= level;
  end

  assign press = level & ~r_level_q;

endmodule

// File: rtl/alu_ctrl.sv
// Operand/op sequencer: capture A, capture B, then cycle ADD->SUB->MOD on enter presses.
// One-cycle latency from press to every registered output; no backpressure, presses are never stalled.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enter,
  input  logic             sign,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic [1:0]       alu_op,
  output logic             op_valid,
  output logic             sign_mode,
  output logic [2:0]       state_o
);

  logic             w_enter_press;
  logic             w_sign_press;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_alu_op;
  logic [1:0]       w_alu_op_nxt;
  logic             r_op_valid;
  logic             w_op_valid_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sign_mode;

  edge_detect u_enter_edge (
    .clk   (clk),
    .rst   (rst),
    .level (enter),
    .press (w_enter_press)
  );

  edge_detect u_sign_edge (
    .clk   (clk),
    .rst   (rst),
    .level (sign),
    .press (w_sign_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_A;
      r_alu_op   <= OP_ADD;
      r_op_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_alu_op   <= w_alu_op_nxt;
      r_op_valid <= w_op_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_enter_press) begin
      case (r_state)
        S_A:     w_state_nxt = S_B;
        S_B:     w_state_nxt = S_ADD;
        S_ADD:   w_state_nxt = S_SUB;
        S_SUB:   w_state_nxt = S_MOD;
        S_MOD:   w_state_nxt = S_ADD;
        default: w_state_nxt = S_A;
      endcase
    end
  end

  // Decoding the next state keeps alu_op/op_valid registered yet aligned with state_o.
  always_comb begin
    w_alu_op_nxt   = op_of_state(w_state_nxt);
    w_op_valid_nxt = (w_state_nxt == S_ADD) || (w_state_nxt == S_SUB) ||
                     (w_state_nxt == S_MOD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sign_mode <= 1'b0;
    end else begin
      if (w_enter_press && r_state == S_A) r_a <= sw_in;
      if (w_enter_press && r_state == S_B) r_b <= sw_in;
      if (w_sign_press) r_sign_mode <= ~r_sign_mode;
    end
  end

  assign a_reg     = r_a;
  assign b_reg     = r_b;
  assign alu_op    = r_alu_op;
  assign op_valid  = r_op_valid;
  assign sign_mode = r_sign_mode;
  assign state_o   = r_state;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: directed test-plan sequences with literal checks, then random buttons,
// all compared every cycle against a phase-counter model of the sequencer.
module tb_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             enter;
  logic             sign;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       alu_op;
  logic             op_valid;
  logic             sign_mode;
  logic [2:0]       state_o;

  int n_vec = 0;
  int n_err = 0;

  alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .enter     (enter),
    .sign      (sign),
    .sw_in     (sw_in),
    .a_reg     (a_reg),
    .b_reg     (b_reg),
    .alu_op    (alu_op),
    .op_valid  (op_valid),
    .sign_mode (sign_mode),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting for A, 1 = waiting for B, 2/3/4 = ADD/SUB/MOD.
  int   m_phase = 0;
  int   m_a     = 0;
  int   m_b     = 0;
  int   m_sign  = 0;
  bit   m_eq    = 0;
  bit   m_sq    = 0;
  bit   m_init  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_a = 0; m_b = 0; m_sign = 0;
      m_eq = 0; m_sq = 0; m_init = 1;
    end else begin
      if (enter && !m_eq) begin
        if (m_phase == 0)      begin m_a = int'(sw_in); m_phase = 1; end
        else if (m_phase == 1) begin m_b = int'(sw_in); m_phase = 2; end
        else                   m_phase = (m_phase == 4) ? 2 : m_phase + 1;
      end
      if (sign && !m_sq) m_sign = 1 - m_sign;
      m_eq = enter;
      m_sq = sign;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("state",     32'(state_o),   32'(m_phase));
      chk("a_reg",     32'(a_reg),     32'(m_a));
      chk("b_reg",     32'(b_reg),     32'(m_b));
      chk("alu_op",    32'(alu_op),    32'((m_phase >= 2) ? m_phase - 2 : 0));
      chk("op_valid",  32'(op_valid),  32'(m_phase >= 2));
      chk("sign_mode", 32'(sign_mode), 32'(m_sign));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press_enter();
    enter = 1'b1; step();
    enter = 1'b0; step();
  endtask

  task automatic do_reset();
    rst = 1'b1; enter = 1'b0; sign = 1'b0;
    step(); step();
    rst = 1'b0; step();
  endtask

  logic [1:0] exp_ops [4];
  logic [2:0] exp_sm  [3];

  initial begin
    rst = 1'b1; enter = 1'b0; sign = 1'b0; sw_in = '0;
    exp_ops[0] = 2'b01; exp_ops[1] = 2'b10; exp_ops[2] = 2'b00; exp_ops[3] = 2'b01;
    exp_sm[0] = 3'd1; exp_sm[1] = 3'd0; exp_sm[2] = 3'd1;

    do_reset();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_a",     32'(a_reg),   32'd0);
    chk("rst_vld",   32'(op_valid), 32'd0);

    // Load A=2D, B=07
    sw_in = 8'h2D; press_enter();
    sw_in = 8'h07; enter = 1'b1; step();
    chk("load_a",     32'(a_reg),    32'h2D);
    chk("load_b",     32'(b_reg),    32'h07);
    chk("load_state", 32'(state_o),  32'd2);
    chk("load_op",    32'(alu_op),   32'd0);
    chk("load_vld",   32'(op_valid), 32'd1);
    enter = 1'b0; sw_in = 8'hA5; step();

    for (int i = 0; i < 4; i++) begin
      enter = 1'b1; step();
      chk("cycle_op", 32'(alu_op), 32'(exp_ops[i]));
      enter = 1'b0; step();
    end
    chk("cycle_a", 32'(a_reg), 32'h2D);
    chk("cycle_b", 32'(b_reg), 32'h07);

    // Held enter in S_A with switches changing mid-hold
    do_reset();
    sw_in = 8'h55; enter = 1'b1; step();
    sw_in = 8'hFF;
    repeat (49) step();
    enter = 1'b0; step();
    chk("hold_state", 32'(state_o), 32'd1);
    chk("hold_a",     32'(a_reg),   32'h55);

    for (int i = 0; i < 3; i++) begin
      sign = 1'b1; step();
      chk("sign_mode", 32'(sign_mode), 32'(exp_sm[i]));
      sign = 1'b0; step();
    end
    chk("sign_state", 32'(state_o), 32'd1);

    // Reach S_SUB, then enter and sign together
    sw_in = 8'h03; press_enter();
    press_enter();
    enter = 1'b1; sign = 1'b1; step();
    chk("simul_state", 32'(state_o),   32'd4);
    chk("simul_op",    32'(alu_op),    32'd2);
    chk("simul_sign",  32'(sign_mode), 32'd0);
    enter = 1'b0; sign = 1'b0; step();

    // Reset in S_MOD with an enter press on the same edge
    do_reset();
    sw_in = 8'h2D; press_enter();
    sw_in = 8'h07; press_enter();
    press_enter(); press_enter();
    chk("pre_rst_state", 32'(state_o), 32'd4);
    sign = 1'b1; step(); sign = 1'b0; step();
    rst = 1'b1; enter = 1'b1; sw_in = 8'h99; step();
    chk("mid_rst_state", 32'(state_o),   32'd0);
    chk("mid_rst_a",     32'(a_reg),     32'd0);
    chk("mid_rst_b",     32'(b_reg),     32'd0);
    chk("mid_rst_op",    32'(alu_op),    32'd0);
    chk("mid_rst_vld",   32'(op_valid),  32'd0);
    chk("mid_rst_sign",  32'(sign_mode), 32'd0);
    enter = 1'b0; step();
    rst = 1'b0; step();
    chk("post_rst_state", 32'(state_o), 32'd0);

    // Random buttons, switches and occasional reset
    for (int i = 0; i < 1500; i++) begin
      enter = ($urandom_range(0, 2) == 0);
      sign  = ($urandom_range(0, 3) == 0);
      sw_in = 8'($urandom);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; enter = 1'b0; sign = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
